// File: rtl/aes.sv
// Iterative AES-128 encryption core: one round per clock, with the key schedule
// expanded on the fly. The result is held on out_data and flagged by a level done.
module aes (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data,
  input  logic [127:0] key,
  input  logic         read_enable,
  output logic [127:0] out_data,
  output logic         done
);

  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned ROUND_W  = 4;
  localparam int unsigned LAST_RND = 10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Column word holds row 0 in its low byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
  endfunction

  fsm_t                 fsm_q, fsm_d;
  logic [BLOCK_W-1:0]   st_q, st_d;
  logic [BLOCK_W-1:0]   rk_q, rk_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [BLOCK_W-1:0]   out_d;
  logic                 done_d;

  logic [BLOCK_W-1:0]   sb, sr, mc, rk_next, round_out;
  logic [31:0]          temp;

  // One AES round plus the matching key-schedule step, fully combinational.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(st_q[8*i +: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
    end
    for (int c = 0; c < 4; c++) mc[32*c +: 32] = mix_col(sr[32*c +: 32]);

    temp = {sbox(rk_q[103:96]), sbox(rk_q[127:120]), sbox(rk_q[119:112]),
            sbox(rk_q[111:104]) ^ rcon(round_q)};
    rk_next[31:0]   = rk_q[31:0]   ^ temp;
    rk_next[63:32]  = rk_q[63:32]  ^ rk_next[31:0];
    rk_next[95:64]  = rk_q[95:64]  ^ rk_next[63:32];
    rk_next[127:96] = rk_q[127:96] ^ rk_next[95:64];

    round_out = ((round_q == ROUND_W'(LAST_RND)) ? sr : mc) ^ rk_next;
  end

  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    rk_d    = rk_q;
    round_d = round_q;
    out_d   = out_data;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (read_enable) begin
          st_d    = data ^ key;
          rk_d    = key;
          round_d = ROUND_W'(1);
          fsm_d   = BUSY;
        end
      end
      BUSY: begin
        st_d    = round_out;
        rk_d    = rk_next;
        round_d = round_q + ROUND_W'(1);
        if (round_q == ROUND_W'(LAST_RND)) begin
          out_d  = round_out;
          done_d = 1'b1;
          fsm_d  = DONE;
        end
      end
      DONE: begin
        // Held high: stay put so a level read_enable yields a single encryption.
        if (read_enable) begin
          done_d = 1'b1;
        end else begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      st_q     <= '0;
      rk_q     <= '0;
      round_q  <= '0;
      out_data <= '0;
      done     <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      st_q     <= st_d;
      rk_q     <= rk_d;
      round_q  <= round_d;
      out_data <= out_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_aes.sv
// Directed bench for the aes core: FIPS-197 vectors, latency, handshake and reset.
module tb_aes;

  logic         clk;
  logic         rst;
  logic [127:0] data;
  logic [127:0] key;
  logic         read_enable;
  logic [127:0] out_data;
  logic         done;

  int checks   = 0;
  int failures = 0;

  aes dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .key        (key),
    .read_enable(read_enable),
    .out_data   (out_data),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Written as a FIPS byte string (byte 0 leftmost); returns byte 0 in bits [7:0].
  function automatic logic [127:0] fb(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[127-8*i -: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures on the next edge, waits (bounded) for done, checks latency and result.
  task automatic encrypt(input string tag, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] exp, input bit scramble);
    int lat;
    data        = p;
    key         = k;
    read_enable = 1'b1;
    tick();
    if (scramble) begin
      data = ~p;
      key  = ~k;
    end
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'd10);
    check({tag, "_ct"}, out_data, exp);
  endtask

  logic [127:0] key_b, pt_b, ct_b, key_c, pt_c, ct_c, ct_z;

  initial begin
    key_b = fb(128'h2b7e151628aed2a6abf7158809cf4f3c);
    pt_b  = fb(128'h3243f6a8885a308d313198a2e0370734);
    ct_b  = fb(128'h3925841d02dc09fbdc118597196a0b32);
    key_c = fb(128'h000102030405060708090a0b0c0d0e0f);
    pt_c  = fb(128'h00112233445566778899aabbccddeeff);
    ct_c  = fb(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    ct_z  = fb(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    rst = 1'b1; read_enable = 1'b0; data = '0; key = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_done", 128'(done), 128'd0);
    check("reset_out", out_data, 128'd0);

    // read_enable unknown or low must not start anything.
    read_enable = 1'bx;
    data = pt_b; key = key_b;
    repeat (3) tick();
    read_enable = 1'b0;
    repeat (12) tick();
    check("idle_x_done", 128'(done), 128'd0);
    check("idle_x_out", out_data, 128'd0);

    // Appendix B with read_enable held high.
    encrypt("fips_b", key_b, pt_b, ct_b, 1'b0);
    check("fips_b_lsb", 128'(out_data[7:0]), 128'h39);
    check("fips_b_msb", 128'(out_data[127:120]), 128'h32);
    repeat (3) tick();
    check("hold_done", 128'(done), 128'd1);
    check("hold_out", out_data, ct_b);
    read_enable = 1'b0;
    tick();
    check("drop_done", 128'(done), 128'd0);
    check("drop_out", out_data, ct_b);

    // Appendix C.1 with inputs disturbed during BUSY.
    encrypt("fips_c1", key_c, pt_c, ct_c, 1'b1);
    read_enable = 1'b0;
    tick();
    check("c1_drop_done", 128'(done), 128'd0);

    encrypt("zero", '0, '0, ct_z, 1'b0);
    read_enable = 1'b0;
    tick();

    // Reset on E5 of a run aborts it.
    data = pt_c; key = key_c; read_enable = 1'b1;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_enable = 1'b0;
    check("abort_done", 128'(done), 128'd0);
    check("abort_out", out_data, 128'd0);
    repeat (12) tick();
    check("abort_idle_done", 128'(done), 128'd0);
    check("abort_idle_out", out_data, 128'd0);

    encrypt("after_rst", key_b, pt_b, ct_b, 1'b0);
    read_enable = 1'b0;
    tick();
    check("final_done", 128'(done), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes.md
# aes

Iterative AES-128 encryption core. Latches a 128-bit plaintext block and a 128-bit cipher key on a start request. Computes the FIPS-197 ciphertext one round per clock, with on-the-fly key expansion. Presents the result with a level `done` flag; sits between a host-side register interface and downstream logic that consumes `out_data`.

## Interface
- No parameters (key size fixed at 128 bits, Nr = 10).
- One clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock for all state.
- `rst` in 1: synchronous, active-high reset.
- `data` in 128: plaintext; FIPS byte i (i = 0 first) at bits [8i+7:8i].
- `key` in 128: cipher key; same byte mapping as `data`.
- `read_enable` in 1: start request / result-hold level.
- `out_data` out 128: ciphertext; same byte mapping.
- `done` out 1: high while `out_data` holds a valid, completed result.

## Operation
- Byte i maps to AES state row i mod 4, column i/4 (column-major, FIPS-197).
- FSM states: IDLE, BUSY, DONE.
- IDLE: on an edge with `read_enable` == 1, latch `data` and `key`. Load state = data XOR key and round key = key, set round counter = 1, go to BUSY. X or 0 on `read_enable` does not start.
- BUSY, each edge with round r (1..10):
  - Compute round key r from round key r-1: RotWord, SubWord, XOR Rcon[r], then chained word XORs.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - Apply SubBytes, then ShiftRows (row k rotated left k bytes).
  - Apply MixColumns for r < 10; skip it for r = 10.
  - AddRoundKey with round key r.
  - Increment r.
- After round 10: write the result to `out_data`, set `done` = 1, go to DONE.
- DONE: hold `out_data` and `done` while `read_enable` = 1. When `read_enable` = 0, clear `done` and go to IDLE. `out_data` keeps the last result.
- S-box: a combinational 256-entry FIPS table function, shared by the 16 state bytes and the 4 key-schedule bytes.
- MixColumns uses xtime (shift left 1, XOR 0x1b if the MSB was set).

## Timing
- Reset, on an edge with `rst` = 1: `out_data` = 0, `done` = 0, state IDLE, round counter 0. Reset has priority over all other inputs in every state; reset during BUSY aborts with no output.
- Latency: call the capture edge E0. Rounds 1..10 execute on E1..E10. `done` and `out_data` are valid after E10, i.e. 10 cycles after capture and 11 edges counting E0.
- `data` and `key` are don't-care after E0; changes during BUSY are ignored.
- `read_enable` deasserted during BUSY: the operation still completes. On E10 `done` rises, then falls one edge later because `read_enable` is 0.
- In DONE, `read_enable` low on edge Ek: `done` = 0 after Ek. A new capture requires `read_enable` = 1 on a later edge in IDLE, so the minimum start-to-start spacing is 12 edges.
- `read_enable` held continuously high: exactly one encryption per assertion. No restart until it drops.
- `done` is never high in IDLE or BUSY.

## Test plan
- FIPS-197 Appendix B: key bytes 2b7e151628aed2a6abf7158809cf4f3c and plaintext bytes 3243f6a8885a308d313198a2e0370734 (byte 0 in bits [7:0]). Pulse reset, then assert `read_enable` = 1 and hold. Required: `done` = 1 exactly 10 cycles after capture, ciphertext bytes 3925841d02dc09fbdc118597196a0b32, so `out_data[7:0]` = 0x39 and `out_data[127:120]` = 0x32.
- FIPS-197 Appendix C.1: key bytes 000102…0f, plaintext bytes 00112233…ff. Required: ciphertext bytes 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and plaintext. Required: ciphertext bytes 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Reset behaviour: assert `rst` on E5 of a run. Required: `done` = 0 and `out_data` = 0 next cycle, FSM in IDLE. A fresh start afterwards produces the correct ciphertext with full latency.
- Handshake: in DONE, drop `read_enable`. Required: `done` falls after one edge and `out_data` is held. Change `data`/`key` during BUSY: the result is unaffected. Reassert `read_enable` with a new vector: a second correct result.
- `read_enable` X or 0 after reset. Required: stays in IDLE, `done` = 0, `out_data` = 0.
